// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the request legality check used at capture time.
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 10
`endif
`ifndef MEMORY_COUNT
`define MEMORY_COUNT 1024
`endif

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WIDTH_WORD = 2'h3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Legal funct3 for the direction and natural alignment for the access size.
    function automatic logic lsu_request_ok(input logic write,
                                            input logic [2:0] funct3,
                                            input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = (offset[0] == 1'b0);
            F3_W:    ok = (offset == 2'b00);
            F3_BU:   ok = !write;
            F3_HU:   ok = !write && (offset[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane logic: merges store data into a memory word and
// extracts/extends load data from it.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store merge: overwrite only the addressed lane(s) of the old word.
    always_comb begin
        merged = rword;
        case (funct3)
            F3_B:    merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    merged = wdata;
            default: merged = rword;
        endcase
    end

    // Load extract with sign or zero extension.
    always_comb begin
        byte_s = rword[{offset, 3'b000} +: 8];
        half_s = rword[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
            F3_BU:   rdata = {24'h000000, byte_s};
            F3_H:    rdata = {{16{half_s[15]}}, half_s};
            F3_HU:   rdata = {16'h0000, half_s};
            F3_W:    rdata = rword;
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed core requests become word accesses,
// with read-modify-write for sub-word stores and a valid/ready response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = `MEMORY_DEPTH,
    parameter int MEM_COUNT  = `MEMORY_COUNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [MEM_DEPTH-1:0]  memory_read_address,
    input  logic [31:0]           memory_read_data,
    output logic [MEM_DEPTH-1:0]  memory_write_address,
    output logic [31:0]           memory_write_data,
    output logic                  memory_write_enable,
    output logic [1:0]            memory_write_width
);

    lsu_state_e              state_r;
    logic                    write_r;
    logic [2:0]              funct3_r;
    logic [1:0]              offset_r;
    logic [31:0]             wdata_r;
    logic [ADDR_WIDTH-3:0]   req_word_s;
    logic                    req_error_s;
    logic [31:0]             merged_s;
    logic [31:0]             rdata_s;

    assign req_word_s         = req_addr[ADDR_WIDTH-1:2];
    assign memory_write_width = WIDTH_WORD;

    // Classify the incoming request; only meaningful when it is accepted.
    always_comb begin
        req_error_s = 1'b0;
        if (!lsu_request_ok(req_write, req_funct3, req_addr[1:0])) begin
            req_error_s = 1'b1;
        end else if (req_word_s >= (ADDR_WIDTH-2)'(MEM_COUNT)) begin
            req_error_s = 1'b1;
        end else begin
            req_error_s = 1'b0;
        end
    end

    // Memory read data feeds the aligner directly; results are registered
    // at the end of READ, so no separate copy of the read word is kept.
    lsu_data_align u_align (
        .rword  (memory_read_data),
        .wdata  (wdata_r),
        .funct3 (funct3_r),
        .offset (offset_r),
        .merged (merged_s),
        .rdata  (rdata_s)
    );

    // Transaction FSM with all core and memory outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r              <= IDLE;
            write_r              <= 1'b0;
            funct3_r             <= 3'b000;
            offset_r             <= 2'b00;
            wdata_r              <= 32'h0000_0000;
            req_ready            <= 1'b1;
            rsp_valid            <= 1'b0;
            rsp_rdata            <= 32'h0000_0000;
            rsp_error            <= 1'b0;
            memory_read_address  <= '0;
            memory_write_address <= '0;
            memory_write_data    <= 32'h0000_0000;
            memory_write_enable  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_r   <= req_write;
                        funct3_r  <= req_funct3;
                        offset_r  <= req_addr[1:0];
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_error_s) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else begin
                            state_r             <= READ;
                            memory_read_address <= req_addr[MEM_DEPTH+1:2];
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (write_r) begin
                        state_r              <= WRITE;
                        memory_write_enable  <= 1'b1;
                        memory_write_address <= memory_read_address;
                        memory_write_data    <= merged_s;
                    end else begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= rdata_s;
                    end
                end
                WRITE: begin
                    state_r             <= RESP;
                    memory_write_enable <= 1'b0;
                    rsp_valid           <= 1'b1;
                    rsp_error           <= 1'b0;
                    rsp_rdata           <= 32'h0000_0000;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        rsp_rdata <= 32'h0000_0000;
                        req_ready <= 1'b1;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r             <= IDLE;
                    req_ready           <= 1'b1;
                    rsp_valid           <= 1'b0;
                    memory_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests scored against a byte-arithmetic reference memory.
module tb_load_store_unit;

    localparam int MEM_DEPTH = 8;
    localparam int MEM_COUNT = 200;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_write = 1'b0;
    logic [2:0]           req_funct3 = 3'b000;
    logic [31:0]          req_addr = 32'h0;
    logic [31:0]          req_wdata = 32'h0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [31:0]          rsp_rdata;
    logic                 rsp_error;
    logic [MEM_DEPTH-1:0] memory_read_address;
    logic [31:0]          memory_read_data;
    logic [MEM_DEPTH-1:0] memory_write_address;
    logic [31:0]          memory_write_data;
    logic                 memory_write_enable;
    logic [1:0]           memory_write_width;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int          wr_count = 0;
    int          wr_base = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .MEM_COUNT(MEM_COUNT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .memory_read_address(memory_read_address), .memory_read_data(memory_read_data),
        .memory_write_address(memory_write_address), .memory_write_data(memory_write_data),
        .memory_write_enable(memory_write_enable), .memory_write_width(memory_write_width)
    );

    assign memory_read_data = mem[memory_read_address];

    always @(posedge clk) begin
        if (memory_write_enable) begin
            mem[memory_write_address] <= memory_write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: applies one request to ref_mem using plain shift/mask arithmetic.
    function automatic void ref_apply(input bit w, input bit [2:0] f3, input bit [31:0] a,
                                      input bit [31:0] d, output bit err,
                                      output bit [31:0] rd, output int lat);
        bit        legal, mis;
        int        idx, bsh, hsh;
        bit [31:0] word, b, h;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) || (f3 == 3'd2 && (a % 4) != 0);
        err   = !legal || mis || ((a / 4) >= MEM_COUNT);
        rd    = 32'h0;
        if (err) begin
            lat = 1;
            return;
        end
        idx  = int'(a / 4);
        word = ref_mem[idx];
        bsh  = int'(a % 4) * 8;
        hsh  = ((a % 4) >= 2) ? 16 : 0;
        if (w) begin
            lat = 3;
            if (f3 == 3'd0)      word = (word & ~(32'hFF << bsh)) | ((d & 32'hFF) << bsh);
            else if (f3 == 3'd1) word = (word & ~(32'hFFFF << hsh)) | ((d & 32'hFFFF) << hsh);
            else                 word = d;
            ref_mem[idx] = word;
        end else begin
            lat = 2;
            b = (word >> bsh) & 32'hFF;
            h = (word >> hsh) & 32'hFFFF;
            if (f3 == 3'd0)      rd = (b >= 128) ? (b - 32'd256) : b;
            else if (f3 == 3'd4) rd = b;
            else if (f3 == 3'd1) rd = (h >= 32768) ? (h - 32'd65536) : h;
            else if (f3 == 3'd5) rd = h;
            else                 rd = word;
        end
    endfunction

    // Presents a request and returns at the falling edge after it is accepted.
    task automatic issue(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        wr_base = wr_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits for the response (from the first falling edge after accept) and scores it.
    task automatic collect(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        bit        err;
        bit [31:0] rd;
        int        lat, exp_lat, idx;
        ref_apply(w, f3, a, d, err, rd, exp_lat);
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_error", {31'b0, rsp_error}, {31'b0, err});
        check("rsp_rdata", rsp_rdata, rd);
        check("write_count", wr_count - wr_base, (w && !err) ? 32'd1 : 32'd0);
        idx = int'((a / 4) % 256);
        if (!err) check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_ack", {30'b0, req_ready, rsp_valid}, 32'd2);
    endtask

    task automatic transact(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        issue(w, f3, a, d);
        collect(w, f3, a, d);
        ack();
    endtask

    initial begin
        logic [31:0] hold_rdata;
        logic        hold_error;
        bit          w;
        bit [2:0]    f3;
        bit [31:0]   a;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        #12;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp", {rsp_rdata[30:0], rsp_valid} | {31'b0, rsp_error}, 32'd0);
        check("rst_mem_out", {memory_read_address, memory_write_address, 15'b0, memory_write_enable},
              32'd0);
        check("write_width", {30'b0, memory_write_width}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;

        // Word round trip
        transact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        check("sw_word4", mem[4], 32'hDEADBEEF);
        transact(1'b0, 3'd2, 32'h10, 32'h0);

        // Byte merge and sign
        transact(1'b1, 3'd2, 32'h10, 32'h11223344);
        transact(1'b1, 3'd0, 32'h12, 32'h000000A5);
        check("sb_merge", mem[4], 32'h11A53344);
        transact(1'b0, 3'd0, 32'h12, 32'h0);
        transact(1'b0, 3'd4, 32'h12, 32'h0);

        // Halfwords
        transact(1'b1, 3'd2, 32'h10, 32'h80017FFF);
        transact(1'b0, 3'd1, 32'h12, 32'h0);
        transact(1'b0, 3'd5, 32'h12, 32'h0);
        transact(1'b0, 3'd1, 32'h10, 32'h0);

        // Errors
        transact(1'b0, 3'd2, 32'h11, 32'h0);
        transact(1'b1, 3'd1, 32'h13, 32'h1234);
        transact(1'b1, 3'd4, 32'h20, 32'h55);
        transact(1'b0, 3'd2, MEM_COUNT * 4, 32'h0);

        // Backpressure with a second request presented while the response waits
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        collect(1'b0, 3'd2, 32'h10, 32'h0);
        hold_rdata = rsp_rdata;
        hold_error = rsp_error;
        req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = 32'h7E;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {rsp_error, req_ready, rsp_valid}, {hold_error, 1'b0, 1'b1});
            check("bp_rdata", rsp_rdata, hold_rdata);
        end
        ack();
        wr_base = wr_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_accept", {31'b0, req_ready}, 32'd0);
        collect(1'b1, 3'd0, 32'h31, 32'h7E);
        ack();

        // Reset during READ of a byte store
        issue(1'b1, 3'd0, 32'h44, 32'h5A);
        wr_base = wr_count;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp", {29'b0, rsp_valid, rsp_error, req_ready}, 32'd1);
        check("mid_rst_out", {memory_read_address, memory_write_address, 15'b0, memory_write_enable},
              32'd0);
        check("mid_rst_wdata", memory_write_data | rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_nowrite", wr_count - wr_base, 32'd0);
        check("mid_rst_word", mem[17], ref_mem[17]);
        check("mid_rst_idle", {30'b0, req_ready, rsp_valid}, 32'd2);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = $urandom_range(0, MEM_COUNT * 4 + 63);
            transact(w, f3, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
